// File: rtl/spi_read_stream_if.sv
// SPI pin bundle plus the read-word valid/ready stream of spi_read_stream.
interface spi_read_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  serial_in;
  logic                  serial_out;
  logic                  spi_clk_en;
  logic                  cs_n;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    input  serial_in, data_ready,
    output serial_out, spi_clk_en, cs_n, data_out, data_valid
  );

  modport slave (
    output serial_in, data_ready,
    input  serial_out, spi_clk_en, cs_n, data_out, data_valid
  );
endinterface

// File: rtl/spi_read_stream.sv
// SPI read master: shifts out a register address, then streams N words out on
// valid/ready, pausing the SPI clock whenever the output slot is still occupied.
module spi_read_stream #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   new_command,
  input  logic                   is_write,
  input  logic [COUNT_WIDTH-1:0] num_regs_to_read,
  input  logic [ADDR_WIDTH-1:0]  start_read_register_addr,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [COUNT_WIDTH-1:0] words_read,
  spi_read_stream_if.master      bus
);
  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BIT_W = $clog2(MAX_W + 1);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_WIDTH - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, READ, STALL, DONE} state_t;
  state_t state, state_nxt;

  logic                   cmd_prev;
  logic [BIT_W-1:0]       bit_cnt;
  logic [ADDR_WIDTH-1:0]  addr_sr;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic [COUNT_WIDTH-1:0] num_lat;
  logic                   abort_flag;

  logic                   start;
  logic                   slot_free;
  logic                   word_done;
  logic                   last_word;
  logic                   take_abort;
  logic                   load_word;
  logic [DATA_WIDTH-1:0]  word_in;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                     input logic b);
    if (LSB_FIRST) return {b, sr[DATA_WIDTH-1:1]};
    else           return {sr[DATA_WIDTH-2:0], b};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] shift_out(input logic [ADDR_WIDTH-1:0] sr);
    if (LSB_FIRST) return sr >> 1;
    else           return sr << 1;
  endfunction

  assign start      = new_command && !cmd_prev && !is_write;
  assign slot_free  = !bus.data_valid || bus.data_ready;
  assign word_done  = (state == READ) && (bit_cnt == DATA_LAST);
  assign last_word  = (words_read + COUNT_WIDTH'(1)) == num_lat;
  // Abort outranks a word completing in the same cycle, so that word is dropped.
  assign take_abort = abort && (state inside {ADDR, READ, STALL});
  assign load_word  = !take_abort && slot_free && (word_done || state == STALL);
  assign word_in    = shift_in(data_sr, bus.serial_in);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_regs_to_read == '0) ? DONE : ADDR;
      ADDR:  if (take_abort) state_nxt = DONE;
             else if (bit_cnt == ADDR_LAST) state_nxt = READ;
      READ:  if (take_abort) state_nxt = DONE;
             else if (word_done) state_nxt = slot_free ? (last_word ? DONE : READ) : STALL;
      STALL: if (take_abort) state_nxt = DONE;
             else if (slot_free) state_nxt = last_word ? DONE : READ;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.serial_out = 1'b0;
    bus.spi_clk_en = 1'b0;
    bus.cs_n       = 1'b1;
    busy           = (state != IDLE);
    done           = 1'b0;
    aborted        = 1'b0;
    case (state)
      ADDR: begin
        bus.serial_out = LSB_FIRST ? addr_sr[0] : addr_sr[ADDR_WIDTH-1];
        bus.spi_clk_en = 1'b1;
        bus.cs_n       = 1'b0;
      end
      READ: begin
        bus.spi_clk_en = 1'b1;
        bus.cs_n       = 1'b0;
      end
      STALL: bus.cs_n = 1'b0;
      DONE: begin
        done    = 1'b1;
        aborted = abort_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_prev       <= 1'b0;
      bit_cnt        <= '0;
      addr_sr        <= '0;
      data_sr        <= '0;
      num_lat        <= '0;
      abort_flag     <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      words_read     <= '0;
    end else begin
      cmd_prev <= new_command;

      // A load in the same cycle as a handshake keeps data_valid high.
      if (load_word) begin
        bus.data_out   <= (state == STALL) ? data_sr : word_in;
        bus.data_valid <= 1'b1;
        words_read     <= words_read + COUNT_WIDTH'(1);
      end else if (bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end

      case (state)
        IDLE: if (start) begin
          num_lat    <= num_regs_to_read;
          addr_sr    <= start_read_register_addr;
          words_read <= '0;
          abort_flag <= 1'b0;
          bit_cnt    <= '0;
        end
        ADDR: begin
          addr_sr <= shift_out(addr_sr);
          bit_cnt <= (bit_cnt == ADDR_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end
        // STALL keeps data_sr frozen, so no bit is lost while the clock is gated.
        READ: if (!take_abort) begin
          data_sr <= word_in;
          bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
        end
        default: ;
      endcase

      if (take_abort) abort_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_read_stream.sv
// Directed bench for spi_read_stream: a slave/scoreboard process on the falling
// edge plus literal spot checks in the stimulus.
module tb_spi_read_stream;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          cmd0, wr0, abort0, busy0, done0, aborted0;
  logic [CW-1:0] n0, wcnt0;
  logic [AW-1:0] addr0;
  logic          cmd1, wr1, abort1, busy1, done1, aborted1;
  logic [CW-1:0] n1, wcnt1;
  logic [AW-1:0] addr1;

  spi_read_stream_if #(.DATA_WIDTH(DW)) bus0 ();
  spi_read_stream_if #(.DATA_WIDTH(DW)) bus1 ();

  spi_read_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rstn(rstn), .new_command(cmd0), .is_write(wr0), .num_regs_to_read(n0),
    .start_read_register_addr(addr0), .abort(abort0), .busy(busy0), .done(done0),
    .aborted(aborted0), .words_read(wcnt0), .bus(bus0.master));

  spi_read_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rstn(rstn), .new_command(cmd1), .is_write(wr1), .num_regs_to_read(n1),
    .start_read_register_addr(addr1), .abort(abort1), .busy(busy1), .done(done1),
    .aborted(aborted1), .words_read(wcnt1), .bus(bus1.master));

  int checks = 0;
  int failures = 0;

  // Transaction expectations, written by the stimulus before each start.
  int            txn_seq = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] sw [4];
  logic [DW-1:0] sw1 = '0;
  int exp_del = 0, exp_gated = 0, exp_wr = 0, exp_ab = 0, exp_rises = 0;

  // Scoreboard state, written only by the falling-edge process.
  int seen_seq = 0, gcnt = 0, rd_idx = 0, en_rises = 0, done_cnt = 0;
  int cs_low = 0, busy_cyc = 0, gcnt1 = 0, done1_cnt = 0, k = 0;
  logic prev_en = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] addr_seen = '0, addr1_seen = '0;
  logic [DW-1:0] got [4];
  logic [DW-1:0] got1 = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      gcnt = 0; rd_idx = 0; en_rises = 0; gcnt1 = 0;
      prev_en = 1'b0; prev_done = 1'b0;
      bus0.serial_in = 1'b0; bus1.serial_in = 1'b0;
    end else begin
      if (txn_seq != seen_seq) begin
        seen_seq = txn_seq; gcnt = 0; rd_idx = 0; en_rises = 0;
      end
      if (!bus0.cs_n) cs_low++;
      if (busy0) busy_cyc++;
      // Slave on u0: ADDR_WIDTH address cycles, then data bits MSB-first.
      if (bus0.spi_clk_en) begin
        check("cs_low_while_clocking", bus0.cs_n, 0);
        if (!prev_en) en_rises++;
        if (gcnt < AW) begin
          check("addr_bit", bus0.serial_out, exp_addr[AW-1-gcnt]);
          addr_seen[AW-1-gcnt] = bus0.serial_out;
          bus0.serial_in = 1'b0;
        end else begin
          check("mosi_low_in_read", bus0.serial_out, 0);
          k = gcnt - AW;
          bus0.serial_in = (k / DW < 4) ? sw[k/DW][DW-1-(k%DW)] : 1'b0;
        end
        gcnt++;
      end
      prev_en = bus0.spi_clk_en;
      if (bus0.data_valid && bus0.data_ready) begin
        if (rd_idx < exp_del) check("data_word", bus0.data_out, sw[rd_idx]);
        else check("unexpected_word_index", rd_idx, exp_del);
        if (rd_idx < 4) got[rd_idx] = bus0.data_out;
        rd_idx++;
      end
      if (done0) begin
        check("done_one_cycle", prev_done, 0);
        check("aborted_flag", aborted0, exp_ab);
        check("words_read", wcnt0, exp_wr);
        check("gated_cycles", gcnt, exp_gated);
        check("gate_bursts", en_rises, exp_rises);
        check("cs_high_at_done", bus0.cs_n, 1);
        done_cnt++;
      end
      prev_done = done0;
      // Slave on u1: data bits of sw1 sent LSB-first.
      if (bus1.spi_clk_en) begin
        if (gcnt1 < AW) begin
          addr1_seen[gcnt1] = bus1.serial_out;
          bus1.serial_in = 1'b0;
        end else begin
          bus1.serial_in = (gcnt1 - AW < DW) ? sw1[gcnt1-AW] : 1'b0;
        end
        gcnt1++;
      end
      if (bus1.data_valid && bus1.data_ready) got1 = bus1.data_out;
      if (done1) done1_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start0(input logic [AW-1:0] a, input int n);
    addr0 = a; n0 = CW'(n); wr0 = 1'b0; exp_addr = a;
    cmd0 = 1'b1; txn_seq++;
    tick();
    cmd0 = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d;
    d = done_cnt;
    for (int i = 0; i < budget && done_cnt == d; i++) tick();
    check("done_within_budget", done_cnt != d, 1);
  endtask

  task automatic wait_valid0(input int budget);
    for (int i = 0; i < budget && !bus0.data_valid; i++) tick();
    check("valid_within_budget", bus0.data_valid, 1);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_serial_out"}, bus0.serial_out, 0);
    check({tag, "_spi_clk_en"}, bus0.spi_clk_en, 0);
    check({tag, "_cs_n"}, bus0.cs_n, 1);
    check({tag, "_data_out"}, bus0.data_out, 0);
    check({tag, "_data_valid"}, bus0.data_valid, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_aborted"}, aborted0, 0);
    check({tag, "_words_read"}, wcnt0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap_cs, snap_busy, snap_done, d1;
    rstn = 1'b0;
    cmd0 = 1'b0; wr0 = 1'b0; abort0 = 1'b0; n0 = '0; addr0 = '0;
    cmd1 = 1'b0; wr1 = 1'b0; abort1 = 1'b0; n1 = '0; addr1 = '0;
    bus0.data_ready = 1'b1; bus1.data_ready = 1'b1;
    sw = '{8'h00, 8'h00, 8'h00, 8'h00};
    got = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    check_reset0("reset");
    rstn = 1'b1;
    tick();

    // 1: address 0xA5, two words with the consumer always ready
    sw = '{8'h3C, 8'hF0, 8'h00, 8'h00};
    exp_del = 2; exp_gated = AW + 2*DW; exp_wr = 2; exp_ab = 0; exp_rises = 1;
    start0(8'hA5, 2);
    wait_done(200);
    repeat (3) tick();
    check("t1_delivered", rd_idx, 2);
    check("t1_addr_bits", addr_seen, 8'hA5);
    check("t1_word0", got[0], 8'h3C);
    check("t1_word1", got[1], 8'hF0);
    check("t1_cs_idle", bus0.cs_n, 1);
    check("t1_busy_idle", busy0, 0);

    // 2: back-pressure stalls the SPI clock on the second word
    bus0.data_ready = 1'b0;
    sw = '{8'h81, 8'h5A, 8'hC3, 8'h00};
    exp_del = 3; exp_gated = AW + 3*DW; exp_wr = 3; exp_ab = 0; exp_rises = 2;
    start0(8'h42, 3);
    wait_valid0(100);
    repeat (15) tick();
    check("t2_stall_gate_off", bus0.spi_clk_en, 0);
    check("t2_stall_cs_low", bus0.cs_n, 0);
    check("t2_stall_words_read", wcnt0, 1);
    repeat (5) tick();
    bus0.data_ready = 1'b1;
    wait_done(200);
    repeat (3) tick();
    check("t2_delivered", rd_idx, 3);
    check("t2_word0", got[0], 8'h81);
    check("t2_word1", got[1], 8'h5A);
    check("t2_word2", got[2], 8'hC3);

    // 3: zero-length read, ignored write, held command level
    exp_del = 0; exp_gated = 0; exp_wr = 0; exp_ab = 0; exp_rises = 0;
    snap_cs = cs_low;
    start0(8'hFF, 0);
    wait_done(20);
    repeat (2) tick();
    check("t3_cs_never_low", cs_low, snap_cs);
    snap_busy = busy_cyc; snap_done = done_cnt;
    n0 = CW'(2); wr0 = 1'b1; cmd0 = 1'b1;
    tick();
    wr0 = 1'b0;
    repeat (20) tick();
    check("t3_write_no_busy", busy_cyc, snap_busy);
    check("t3_no_retrigger", done_cnt, snap_done);
    check("t3_write_cs_high", cs_low, snap_cs);
    cmd0 = 1'b0;
    tick();

    // 4: abort five bits into the second word
    sw = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_del = 1; exp_gated = AW + DW + 6; exp_wr = 1; exp_ab = 1; exp_rises = 1;
    start0(8'h5C, 4);
    for (int i = 0; i < 200 && gcnt != AW + DW + 5; i++) tick();
    check("t4_abort_point", gcnt, AW + DW + 5);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("t4_cs_high_after_abort", bus0.cs_n, 1);
    check("t4_gate_off_after_abort", bus0.spi_clk_en, 0);
    check("t4_done", done0, 1);
    check("t4_aborted", aborted0, 1);
    wait_done(20);
    repeat (3) tick();
    check("t4_delivered", rd_idx, 1);
    check("t4_word0", got[0], 8'h11);

    // 5: LSB-first instance
    sw1 = 8'h01; addr1 = 8'h01; n1 = CW'(1);
    cmd1 = 1'b1;
    tick();
    cmd1 = 1'b0;
    d1 = done1_cnt;
    for (int i = 0; i < 100 && done1_cnt == d1; i++) tick();
    check("t5_done_within_budget", done1_cnt != d1, 1);
    repeat (3) tick();
    check("t5_addr_bits_in_order", addr1_seen, 8'h01);
    check("t5_word", got1, 8'h01);
    check("t5_words_read", wcnt1, 1);

    // 6: asynchronous reset mid-READ with a word pending, then a clean rerun
    bus0.data_ready = 1'b0;
    sw = '{8'h96, 8'h69, 8'h00, 8'h00};
    exp_del = 2; exp_gated = AW + 2*DW; exp_wr = 2; exp_ab = 0; exp_rises = 1;
    start0(8'hC3, 2);
    wait_valid0(100);
    repeat (3) tick();
    check("t6_in_read", bus0.spi_clk_en, 1);
    #2 rstn = 1'b0;
    #1;
    check_reset0("t6_reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    bus0.data_ready = 1'b1;
    tick();
    sw = '{8'hE1, 8'h1E, 8'h00, 8'h00};
    exp_del = 2; exp_gated = AW + 2*DW; exp_wr = 2; exp_ab = 0; exp_rises = 1;
    start0(8'h3C, 2);
    wait_done(200);
    repeat (3) tick();
    check("t6_delivered", rd_idx, 2);
    check("t6_word0", got[0], 8'hE1);
    check("t6_word1", got[1], 8'h1E);
    check("t6_addr_bits", addr_seen, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_read_stream.md
Name: spi_read_stream

Overview:
Parametrised SPI read master. It shifts out a start-register address, then clocks in N data words and delivers each word on a valid/ready stream toward the readout FIFO/mux. Width, bit order and word count are configurable. Unlike the single-byte-pulse read engine, it applies back-pressure by pausing the SPI clock, supports abort, and reports progress. It sits between the command decoder and the readback FIFO in the SPI driver.

Parameters:
ADDR_WIDTH, 8, number of address bits shifted out before data.
DATA_WIDTH, 8, bits per read word; must be at least 2.
COUNT_WIDTH, 8, width of the word-count input and the progress counter.
LSB_FIRST, 0, 0 = MSB-first on both address and data; 1 = LSB-first on both.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rstn  in  1  asynchronous active-low reset.
new_command  in  1  level input; a rising edge starts a transaction.
is_write  in  1  when high at the start edge, the command is ignored.
num_regs_to_read  in  COUNT_WIDTH  number of words to read; sampled at start.
start_read_register_addr  in  ADDR_WIDTH  address; sampled at start.
abort  in  1  terminates the active transaction.
serial_in  in  1  MISO.
serial_out  out  1  MOSI.
spi_clk_en  out  1  SPI clock gate to the clock generator.
cs_n  out  1  chip select, active low.
data_out  out  DATA_WIDTH  read word.
data_valid  out  1  data_out holds an unconsumed word.
data_ready  in  1  consumer accepts the word when data_valid and data_ready are both high.
busy  out  1  high in any non-IDLE state.
done  out  1  one-cycle pulse at the end of the transaction.
aborted  out  1  valid with done; 1 if the transaction ended by abort.
words_read  out  COUNT_WIDTH  words loaded into data_out in the current or last transaction.

Behaviour:
- Reset values: serial_out=0, spi_clk_en=0, cs_n=1, data_out=0, data_valid=0, busy=0, done=0, aborted=0, words_read=0, state=IDLE, new_command history register=0.
- Reset asserted mid-transaction: everything returns to reset values at once, and any pending word is dropped.
- States: IDLE, ADDR, READ, STALL, DONE.
- Start condition: new_command=1, previous new_command=0, and is_write=0.
  - If new_command is already high when reset releases, it counts as an edge.
- IDLE:
  - Start with num_regs_to_read≠0: latch count and address, set words_read=0, go to ADDR.
  - Start with num_regs_to_read=0: go to DONE with cs_n held at 1 and no clocking.
  - Edges that arrive while not in IDLE are ignored.
- ADDR:
  - cs_n=0 and spi_clk_en=1.
  - Drives one address bit per cycle for exactly ADDR_WIDTH cycles, in the order set by LSB_FIRST.
  - Then goes to READ with serial_out=0.
- READ:
  - spi_clk_en=1, serial_out=0.
  - serial_in is shifted into the shift register at each clock edge ending a READ cycle.
  - Shift order follows LSB_FIRST; the first bit received is the MSB when LSB_FIRST=0.
- Word complete (DATA_WIDTH bits received):
  - If the output slot is free (data_valid=0, or it is being consumed this cycle), load data_out, set data_valid=1 on the next cycle, and increment words_read.
  - Otherwise go to STALL.
- STALL:
  - spi_clk_en=0, cs_n stays 0, and the shift register is held.
  - When the slot frees, load the word, then resume READ or go to DONE after the last word.
  - Back-pressure never loses or duplicates a bit.
- After the last word is loaded: go to DONE.
- DONE: cs_n=1, spi_clk_en=0, done=1 for one cycle, then IDLE.
  - A pending data_valid is allowed to persist past done.
- data_valid clears on a handshake unless a new word loads in the same cycle, in which case it stays 1.
- Abort in ADDR, READ or STALL:
  - Next cycle: spi_clk_en=0 and cs_n=1; the partial word is discarded; the next state is DONE with aborted=1.
  - A pending data_valid word is kept.
  - Abort in IDLE or DONE has no effect.
  - If a word completes in the same cycle as abort, the abort wins and that word is discarded.
- Ungated cycles per transaction: spi_clk_en is high for exactly ADDR_WIDTH + N×DATA_WIDTH cycles.

Test Plan:
1. Defaults, address 0xA5, N=2, slave returns 0x3C then 0xF0, data_ready=1 -> serial_out bits 1,0,1,0,0,1,0,1; spi_clk_en high for 24 contiguous cycles; data_out 0x3C then 0xF0 with one data_valid pulse each; words_read=2; one done pulse with aborted=0; cs_n=1 afterwards.
2. N=3, data_ready=0 until 20 cycles after the first data_valid -> word 2 completes and the engine enters STALL with spi_clk_en=0; on ready the words arrive in order with no bit loss; spi_clk_en high for exactly 32 cycles in total.
3. N=0, then is_write=1 with an edge, then new_command held high (no second edge) -> N=0 gives a done pulse with cs_n never low; the write command gives no activity; the held level does not retrigger.
4. N=4, abort asserted 5 bits into word 2 -> cs_n=1 next cycle; done=1 with aborted=1; words_read=1; the first word is still delivered.
5. LSB_FIRST=1, address 0x01, slave bits 1,0,0,0,0,0,0,0 -> serial_out bits 1,0,0,0,0,0,0,0; data_out=0x01.
6. rstn pulsed low during READ with data_valid=1 -> all outputs at reset values immediately; a new start after reset completes normally.
